// File: rtl/tri_raster.sv
// tri_raster - bounding-box triangle rasteriser.
// Takes one triangle per valid/ready handshake, walks its screen-clamped
// bounding box row by row and streams one pixel per cycle with an inside flag.
// Edge functions are held at full precision and updated incrementally, so the
// scan needs only adders; the multipliers are used once per triangle in SETUP.
module tri_raster #(
  parameter int WIDTH     = 800,
  parameter int HEIGHT    = 600,
  parameter int INTEGER   = 10,
  parameter int DECIMAL   = 7,
  parameter int PRECISION = 1 + INTEGER + DECIMAL,
  parameter int CW        = 1,
  localparam int XW = $clog2(WIDTH),
  localparam int YW = $clog2(HEIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic [PRECISION-1:0] in_x1,
  input  logic [PRECISION-1:0] in_y1,
  input  logic [PRECISION-1:0] in_x2,
  input  logic [PRECISION-1:0] in_y2,
  input  logic [PRECISION-1:0] in_x3,
  input  logic [PRECISION-1:0] in_y3,
  input  logic [3*CW-1:0]      in_color,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic [XW-1:0]        out_x,
  output logic [YW-1:0]        out_y,
  output logic                 out_hit,
  output logic [3*CW-1:0]      out_color,
  output logic                 out_last
);

  localparam int ACC = 2 * PRECISION + 4;
  // Offset of a pixel centre (0.5) in vertex fixed point.
  localparam logic signed [ACC-1:0] HALF = {{(ACC-1){1'b0}}, 1'b1} <<< (DECIMAL - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SCAN = 2'd2} state_t;

  function automatic logic signed [ACC-1:0] ext_f(input logic signed [PRECISION-1:0] v);
    ext_f = {{(ACC-PRECISION){v[PRECISION-1]}}, v};
  endfunction

  // E_ab(p) = (bx-ax)(py-ay) - (by-ay)(px-ax), no rounding anywhere.
  function automatic logic signed [ACC-1:0] edge_f(
    input logic signed [ACC-1:0] ax, ay, bx, by, px, py);
    edge_f = (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  // Inclusive inside test; the area sign picks which side counts as inside.
  function automatic logic hit_f(input logic signed [ACC-1:0] e0, e1, e2, input logic pos);
    if (pos) begin
      hit_f = !e0[ACC-1] && !e1[ACC-1] && !e2[ACC-1];
    end else begin
      hit_f = (e0[ACC-1] || (e0 == {ACC{1'b0}})) &&
              (e1[ACC-1] || (e1 == {ACC{1'b0}})) &&
              (e2[ACC-1] || (e2 == {ACC{1'b0}}));
    end
  endfunction

  function automatic int min3(input int a, input int b, input int c);
    min3 = (a < b) ? ((a < c) ? a : c) : ((b < c) ? b : c);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    max3 = (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction

  state_t                        state_q, state_d;
  logic                          in_rdy_q, in_rdy_d;
  logic signed [PRECISION-1:0]   vx_q [3], vx_d [3], vy_q [3], vy_d [3];
  logic [3*CW-1:0]               color_q, color_d;
  logic [XW-1:0]                 xmin_q, xmin_d, xmax_q, xmax_d;
  logic [YW-1:0]                 ymax_q, ymax_d;
  logic                          area_pos_q, area_pos_d;
  logic signed [ACC-1:0]         stepx_q [3], stepx_d [3], stepy_q [3], stepy_d [3];
  logic signed [ACC-1:0]         e_q [3], e_d [3], erow_q [3], erow_d [3];
  logic                          out_vld_q, out_vld_d, out_hit_q, out_hit_d, out_last_q, out_last_d;
  logic [XW-1:0]                 out_x_q, out_x_d;
  logic [YW-1:0]                 out_y_q, out_y_d;
  logic [3*CW-1:0]               out_color_q, out_color_d;

  int                            bxmin_s, bxmax_s, bymin_s, bymax_s, xlo_s, xhi_s, ylo_s, yhi_s;
  logic signed [ACC-1:0]         area_s, px_s, py_s;
  logic signed [ACC-1:0]         e_start_s [3], stepx_s [3], stepy_s [3];
  logic                          empty_s, hit_start_s;
  logic [XW-1:0]                 nx_s;
  logic [YW-1:0]                 ny_s;
  logic signed [ACC-1:0]         e_nxt_s [3], erow_nxt_s [3];
  logic                          hit_nxt_s, last_nxt_s;

  // Ready is held low combinationally while reset is asserted so it reads 1
  // exactly from the first cycle after reset is released.
  assign in_rdy    = in_rdy_q && !rst;
  assign out_vld   = out_vld_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_hit   = out_hit_q;
  assign out_color = out_color_q;
  assign out_last  = out_last_q;

  // Per-triangle setup: bounding box, area, edge steps and first-pixel edge values
  always_comb begin
    bxmin_s = min3(int'(vx_q[0] >>> DECIMAL), int'(vx_q[1] >>> DECIMAL), int'(vx_q[2] >>> DECIMAL));
    bxmax_s = max3(int'(vx_q[0] >>> DECIMAL), int'(vx_q[1] >>> DECIMAL), int'(vx_q[2] >>> DECIMAL));
    bymin_s = min3(int'(vy_q[0] >>> DECIMAL), int'(vy_q[1] >>> DECIMAL), int'(vy_q[2] >>> DECIMAL));
    bymax_s = max3(int'(vy_q[0] >>> DECIMAL), int'(vy_q[1] >>> DECIMAL), int'(vy_q[2] >>> DECIMAL));
    area_s  = edge_f(ext_f(vx_q[0]), ext_f(vy_q[0]), ext_f(vx_q[1]), ext_f(vy_q[1]),
                     ext_f(vx_q[2]), ext_f(vy_q[2]));
    empty_s = (bxmax_s < 32'sd0) || (bymax_s < 32'sd0) || (bxmin_s >= WIDTH) ||
              (bymin_s >= HEIGHT) || (area_s == {ACC{1'b0}});
    xlo_s = (bxmin_s < 32'sd0) ? 32'sd0 : bxmin_s;
    ylo_s = (bymin_s < 32'sd0) ? 32'sd0 : bymin_s;
    xhi_s = (bxmax_s > WIDTH - 1) ? WIDTH - 1 : bxmax_s;
    yhi_s = (bymax_s > HEIGHT - 1) ? HEIGHT - 1 : bymax_s;
    px_s  = (ACC'(xlo_s) <<< DECIMAL) + HALF;
    py_s  = (ACC'(ylo_s) <<< DECIMAL) + HALF;
    for (int k = 0; k < 3; k++) begin
      e_start_s[k] = edge_f(ext_f(vx_q[k]), ext_f(vy_q[k]), ext_f(vx_q[(k+1)%3]),
                            ext_f(vy_q[(k+1)%3]), px_s, py_s);
      stepx_s[k]   = -((ext_f(vy_q[(k+1)%3]) - ext_f(vy_q[k])) <<< DECIMAL);
      stepy_s[k]   = (ext_f(vx_q[(k+1)%3]) - ext_f(vx_q[k])) <<< DECIMAL;
    end
    hit_start_s = hit_f(e_start_s[0], e_start_s[1], e_start_s[2], !area_s[ACC-1]);
  end

  // Next pixel in scan order and its edge values, used when the current one transfers
  always_comb begin
    nx_s = out_x_q + XW'(1);
    ny_s = out_y_q;
    for (int k = 0; k < 3; k++) begin
      erow_nxt_s[k] = erow_q[k];
      e_nxt_s[k]    = e_q[k] + stepx_q[k];
    end
    if (out_x_q == xmax_q) begin
      nx_s = xmin_q;
      ny_s = out_y_q + YW'(1);
      for (int k = 0; k < 3; k++) begin
        erow_nxt_s[k] = erow_q[k] + stepy_q[k];
        e_nxt_s[k]    = erow_q[k] + stepy_q[k];
      end
    end else begin
      nx_s = out_x_q + XW'(1);
      ny_s = out_y_q;
    end
    hit_nxt_s  = hit_f(e_nxt_s[0], e_nxt_s[1], e_nxt_s[2], area_pos_q);
    last_nxt_s = (nx_s == xmax_q) && (ny_s == ymax_q);
  end

  // Control FSM and datapath next-state
  always_comb begin
    state_d     = state_q;
    in_rdy_d    = in_rdy_q;
    vx_d        = vx_q;
    vy_d        = vy_q;
    color_d     = color_q;
    xmin_d      = xmin_q;
    xmax_d      = xmax_q;
    ymax_d      = ymax_q;
    area_pos_d  = area_pos_q;
    stepx_d     = stepx_q;
    stepy_d     = stepy_q;
    e_d         = e_q;
    erow_d      = erow_q;
    out_vld_d   = out_vld_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_hit_d   = out_hit_q;
    out_color_d = out_color_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (in_vld && in_rdy) begin
          vx_d[0]  = in_x1;
          vy_d[0]  = in_y1;
          vx_d[1]  = in_x2;
          vy_d[1]  = in_y2;
          vx_d[2]  = in_x3;
          vy_d[2]  = in_y3;
          color_d  = in_color;
          in_rdy_d = 1'b0;
          state_d  = SETUP;
        end else begin
          state_d  = IDLE;
        end
      end
      SETUP: begin
        if (empty_s) begin
          state_d  = IDLE;
          in_rdy_d = 1'b1;
        end else begin
          state_d     = SCAN;
          xmin_d      = XW'(xlo_s);
          xmax_d      = XW'(xhi_s);
          ymax_d      = YW'(yhi_s);
          area_pos_d  = !area_s[ACC-1];
          stepx_d     = stepx_s;
          stepy_d     = stepy_s;
          e_d         = e_start_s;
          erow_d      = e_start_s;
          out_vld_d   = 1'b1;
          out_x_d     = XW'(xlo_s);
          out_y_d     = YW'(ylo_s);
          out_hit_d   = hit_start_s;
          out_color_d = hit_start_s ? color_q : {(3*CW){1'b0}};
          out_last_d  = (xlo_s == xhi_s) && (ylo_s == yhi_s);
        end
      end
      SCAN: begin
        if (!out_vld_q || out_rdy) begin
          if (out_last_q) begin
            state_d    = IDLE;
            in_rdy_d   = 1'b1;
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
          end else begin
            out_x_d     = nx_s;
            out_y_d     = ny_s;
            e_d         = e_nxt_s;
            erow_d      = erow_nxt_s;
            out_hit_d   = hit_nxt_s;
            out_color_d = hit_nxt_s ? color_q : {(3*CW){1'b0}};
            out_last_d  = last_nxt_s;
          end
        end else begin
          state_d = SCAN;
        end
      end
      default: begin
        state_d   = IDLE;
        in_rdy_d  = 1'b1;
        out_vld_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; synchronous reset drops any triangle in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_rdy_q    <= 1'b1;
      color_q     <= {(3*CW){1'b0}};
      xmin_q      <= {XW{1'b0}};
      xmax_q      <= {XW{1'b0}};
      ymax_q      <= {YW{1'b0}};
      area_pos_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_x_q     <= {XW{1'b0}};
      out_y_q     <= {YW{1'b0}};
      out_hit_q   <= 1'b0;
      out_color_q <= {(3*CW){1'b0}};
      out_last_q  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        vx_q[k]    <= {PRECISION{1'b0}};
        vy_q[k]    <= {PRECISION{1'b0}};
        stepx_q[k] <= {ACC{1'b0}};
        stepy_q[k] <= {ACC{1'b0}};
        e_q[k]     <= {ACC{1'b0}};
        erow_q[k]  <= {ACC{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      in_rdy_q    <= in_rdy_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
      color_q     <= color_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymax_q      <= ymax_d;
      area_pos_q  <= area_pos_d;
      stepx_q     <= stepx_d;
      stepy_q     <= stepy_d;
      e_q         <= e_d;
      erow_q      <= erow_d;
      out_vld_q   <= out_vld_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_hit_q   <= out_hit_d;
      out_color_q <= out_color_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_tri_raster.sv
// tb_tri_raster - directed and randomized bench for tri_raster.
// Expected pixel streams come from a direct per-pixel evaluation of the edge
// functions over the clamped bounding box.
module tb_tri_raster;

  localparam int W = 800;
  localparam int H = 600;
  localparam int D = 7;
  localparam int P = 18;

  logic clk = 1'b0;
  logic rst, in_vld, in_rdy, out_vld, out_rdy, out_hit, out_last;
  logic [P-1:0] in_x1, in_y1, in_x2, in_y2, in_x3, in_y3;
  logic [2:0] in_color, out_color;
  logic [9:0] out_x, out_y;

  int n_assert = 0;
  int n_fail = 0;

  typedef struct { int x; int y; bit hit; bit last; } pix_t;
  pix_t exp_q[$];
  logic [2:0] exp_col;

  always #5 clk = ~clk;

  tri_raster #(.WIDTH(W), .HEIGHT(H), .INTEGER(10), .DECIMAL(D), .CW(1)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_x1(in_x1), .in_y1(in_y1), .in_x2(in_x2), .in_y2(in_y2),
    .in_x3(in_x3), .in_y3(in_y3), .in_color(in_color),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_x(out_x), .out_y(out_y),
    .out_hit(out_hit), .out_color(out_color), .out_last(out_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int min3(int a, int b, int c);
    int m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int max3(int a, int b, int c);
    int m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic longint edge_ref(longint ax, longint ay, longint bx, longint by,
                                      longint px, longint py);
    return (bx - ax) * (py - ay) - (by - ay) * (px - ax);
  endfunction

  // Reference: every pixel of the clamped box, inside test evaluated directly.
  task automatic model(input int x1, input int y1, input int x2, input int y2,
                       input int x3, input int y3, input logic [2:0] col);
    int xl, xh, yl, yh;
    longint area, px, py, e1, e2, e3;
    pix_t p;
    exp_q.delete();
    exp_col = col;
    area = edge_ref(x1, y1, x2, y2, x3, y3);
    xl = min3(x1 >>> D, x2 >>> D, x3 >>> D);
    xh = max3(x1 >>> D, x2 >>> D, x3 >>> D);
    yl = min3(y1 >>> D, y2 >>> D, y3 >>> D);
    yh = max3(y1 >>> D, y2 >>> D, y3 >>> D);
    if (area == 0 || xh < 0 || yh < 0 || xl >= W || yl >= H) return;
    if (xl < 0) xl = 0;
    if (yl < 0) yl = 0;
    if (xh > W - 1) xh = W - 1;
    if (yh > H - 1) yh = H - 1;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        px = longint'(x) * (1 << D) + (1 << (D - 1));
        py = longint'(y) * (1 << D) + (1 << (D - 1));
        e1 = edge_ref(x1, y1, x2, y2, px, py);
        e2 = edge_ref(x2, y2, x3, y3, px, py);
        e3 = edge_ref(x3, y3, x1, y1, px, py);
        p.x = x;
        p.y = y;
        p.hit = (area > 0) ? (e1 >= 0 && e2 >= 0 && e3 >= 0) : (e1 <= 0 && e2 <= 0 && e3 <= 0);
        p.last = (x == xh) && (y == yh);
        exp_q.push_back(p);
      end
    end
  endtask

  // Present one triangle and return at the falling edge after its accept.
  task automatic send(input int x1, input int y1, input int x2, input int y2,
                      input int x3, input int y3, input logic [2:0] col);
    int waited = 0;
    @(negedge clk);
    while (in_rdy !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", waited < 100, 1);
    in_vld = 1'b1;
    in_x1 = x1[P-1:0]; in_y1 = y1[P-1:0];
    in_x2 = x2[P-1:0]; in_y2 = y2[P-1:0];
    in_x3 = x3[P-1:0]; in_y3 = y3[P-1:0];
    in_color = col;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_x1 = P'($urandom); in_y1 = P'($urandom); in_color = 3'($urandom);
    @(negedge clk);
  endtask

  // mode 0: always ready, 1: random backpressure and junk in_vld,
  // 2: 5-cycle stall at pixel index sidx, 3: stop (ready low) at pixel index sidx.
  task automatic collect(input int mode, input int sidx, output int nhits);
    int sent = 0, cyc = 0, stall = 0;
    bit done = 0, prev_stall = 0;
    logic [9:0] hx, hy;
    logic hh, hl;
    logic [2:0] hc;
    pix_t e;
    nhits = 0;
    chk("setup_vld_low", out_vld, 0);
    chk("setup_rdy_low", in_rdy, 0);
    if (exp_q.size() == 0) begin
      @(negedge clk);
      chk("empty_rdy_back", in_rdy, 1);
      chk("empty_no_vld", out_vld, 0);
      repeat (3) begin
        @(negedge clk);
        chk("empty_still_no_vld", out_vld, 0);
      end
      return;
    end
    @(negedge clk);
    chk("first_vld", out_vld, 1);
    while (!done && cyc < 5000) begin
      case (mode)
        1: begin
          out_rdy = ($urandom_range(0, 3) != 0);
          in_vld = ($urandom_range(0, 1) == 1);
        end
        2: begin
          if (sent == sidx && stall < 5) begin
            out_rdy = 1'b0;
            stall++;
          end else out_rdy = 1'b1;
        end
        3: begin
          if (sent == sidx) begin
            out_rdy = 1'b0;
            return;
          end else out_rdy = 1'b1;
        end
        default: out_rdy = 1'b1;
      endcase
      if (prev_stall) begin
        chk("hold_vld", out_vld, 1);
        chk("hold_x", out_x, hx);
        chk("hold_y", out_y, hy);
        chk("hold_hit", out_hit, hh);
        chk("hold_color", out_color, hc);
        chk("hold_last", out_last, hl);
      end
      if (out_vld === 1'b1 && out_rdy) begin
        if (exp_q.size() == 0) begin
          chk("extra_pixel", 1, 0);
          done = 1;
        end else begin
          e = exp_q.pop_front();
          chk("pix_x", out_x, e.x);
          chk("pix_y", out_y, e.y);
          chk("pix_hit", out_hit, e.hit);
          chk("pix_color", out_color, e.hit ? exp_col : 3'b000);
          chk("pix_last", out_last, e.last);
          if (out_hit === 1'b1) nhits++;
          sent++;
          if (out_last === 1'b1) begin
            done = 1;
            in_vld = 1'b0;
          end
        end
      end
      prev_stall = (out_vld === 1'b1) && !out_rdy;
      hx = out_x; hy = out_y; hh = out_hit; hl = out_last; hc = out_color;
      @(negedge clk);
      cyc++;
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    chk("scan_done_in_budget", done, 1);
    chk("all_delivered", exp_q.size(), 0);
    chk("rdy_after_last", in_rdy, 1);
    chk("vld_after_last", out_vld, 0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nh;
    rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    in_x1 = '0; in_y1 = '0; in_x2 = '0; in_y2 = '0; in_x3 = '0; in_y3 = '0; in_color = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_hit", out_hit, 0);
    chk("rst_out_x", out_x, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_color", out_color, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_rdy", in_rdy, 1);

    // Basic right triangle, positive area
    model(0, 0, 512, 0, 0, 512, 3'b101);
    send(0, 0, 512, 0, 0, 512, 3'b101);
    collect(0, 0, nh);
    chk("tri1_hits", nh, 10);

    // Same triangle, opposite winding
    model(512, 0, 0, 0, 0, 512, 3'b101);
    send(512, 0, 0, 0, 0, 512, 3'b101);
    collect(0, 0, nh);
    chk("tri1_swapped_hits", nh, 10);

    // Collinear: zero area
    model(0, 0, 256, 256, 512, 512, 3'b111);
    send(0, 0, 256, 256, 512, 512, 3'b111);
    collect(0, 0, nh);

    // Entirely off-screen
    model(-40 * 128, -40 * 128, -10 * 128, -40 * 128, -10 * 128, -5 * 128, 3'b011);
    send(-40 * 128, -40 * 128, -10 * 128, -40 * 128, -10 * 128, -5 * 128, 3'b011);
    collect(0, 0, nh);

    // Bottom-right corner, box clamped to 10x10
    model(790 * 128, 590 * 128, 820 * 128, 590 * 128, 790 * 128, 620 * 128, 3'b110);
    chk("corner_model_size", exp_q.size(), 100);
    send(790 * 128, 590 * 128, 820 * 128, 590 * 128, 790 * 128, 620 * 128, 3'b110);
    collect(0, 0, nh);
    chk("corner_hits", nh, 100);

    // Backpressure: 5-cycle stall at pixel (2,1)
    model(0, 0, 512, 0, 0, 512, 3'b101);
    send(0, 0, 512, 0, 0, 512, 3'b101);
    collect(2, 7, nh);
    chk("stall_hits", nh, 10);

    // Reset in the middle of a scan at pixel (3,2)
    model(0, 0, 512, 0, 0, 512, 3'b101);
    send(0, 0, 512, 0, 0, 512, 3'b101);
    collect(3, 13, nh);
    chk("abort_x", out_x, 3);
    chk("abort_y", out_y, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_vld", out_vld, 0);
    chk("midrst_in_rdy", in_rdy, 0);
    chk("midrst_out_x", out_x, 0);
    chk("midrst_out_last", out_last, 0);
    @(negedge clk);
    chk("midrst_in_rdy_2", in_rdy, 0);
    rst = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
    chk("midrst_rdy_back", in_rdy, 1);
    chk("midrst_vld_still_low", out_vld, 0);
    model(10 * 128 + 37, 20 * 128 + 5, 16 * 128 + 90, 21 * 128, 12 * 128, 27 * 128 + 100, 3'b010);
    send(10 * 128 + 37, 20 * 128 + 5, 16 * 128 + 90, 21 * 128, 12 * 128, 27 * 128 + 100, 3'b010);
    collect(0, 0, nh);

    // Randomized triangles with random backpressure
    for (int t = 0; t < 24; t++) begin
      int cx, cy;
      int v[6];
      logic [2:0] c;
      cx = int'($urandom_range(0, W + 40)) - 20;
      cy = int'($urandom_range(0, H + 40)) - 20;
      for (int i = 0; i < 3; i++) begin
        v[2*i]   = (cx + int'($urandom_range(0, 24)) - 12) * 128 + int'($urandom_range(0, 127));
        v[2*i+1] = (cy + int'($urandom_range(0, 24)) - 12) * 128 + int'($urandom_range(0, 127));
      end
      c = 3'($urandom);
      model(v[0], v[1], v[2], v[3], v[4], v[5], c);
      send(v[0], v[1], v[2], v[3], v[4], v[5], c);
      collect(1, 0, nh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
